// File: rtl/verificador_jogadas_pkg.sv
// Shared definitions for the guessing-round controller: FSM state
// encodings, coordinate range/width and a coordinate range check.
package verificador_jogadas_pkg;

    localparam int COORD_W   = 4;
    localparam int COORD_MIN = 1;
    localparam int COORD_MAX = 8;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PEDE    = 4'd1,
        CAPTURA = 4'd2,
        ESP_COL = 4'd3,
        ESP_LIN = 4'd4,
        COMPARA = 4'd5,
        ACERTO  = 4'd6,
        ERRO    = 4'd7,
        TEMPO   = 4'd8
    } estado_t;

    // True when a coordinate lies on the board (1..8).
    function automatic logic coord_valida(input logic [COORD_W-1:0] c);
        return (c >= COORD_W'(COORD_MIN)) && (c <= COORD_W'(COORD_MAX));
    endfunction

endpackage

// File: rtl/codificador_botoes.sv
// Keypad front end: turns the 8-button one-hot keypad into a single-cycle
// "new press" strobe plus the pressed value (bit k -> value k+1).
// A press only counts if exactly one button is down and the keypad was
// fully released in the previous cycle, so held or chorded keys are ignored.
module codificador_botoes
    import verificador_jogadas_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [7:0]         i_botoes,
    output logic               o_valido,
    output logic [COORD_W-1:0] o_valor
);

    logic [7:0] r_botoes_ant;
    logic       w_um_bit;

    // Remember last cycle's keypad so a release can be required between presses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_botoes_ant <= '0;
        end else begin
            r_botoes_ant <= i_botoes;
        end
    end

    assign w_um_bit = (i_botoes != 8'd0) && ((i_botoes & (i_botoes - 8'd1)) == 8'd0);
    assign o_valido = w_um_bit && (r_botoes_ant == 8'd0);

    // One-hot to value; only meaningful when o_valido is high.
    always_comb begin
        o_valor = '0;
        for (int k = 0; k < 8; k++) begin
            if (i_botoes[k]) begin
                o_valor = COORD_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/verificador_jogadas.sv
// Round controller: requests a target square from the move generator,
// collects the player's column-then-row answer from the keypad, judges it
// (hit / miss / keypress timeout) and keeps a saturating score of hits.
module verificador_jogadas
    import verificador_jogadas_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int LARGURA_PONTOS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic [7:0]                botoes,
    input  logic [3:0]                coluna,
    input  logic [3:0]                linha,
    output logic                      novaJogada,
    output logic [3:0]                alvo_coluna,
    output logic [3:0]                alvo_linha,
    output logic [3:0]                jogada_coluna,
    output logic [3:0]                jogada_linha,
    output logic                      acertou,
    output logic                      errou,
    output logic                      timeout,
    output logic                      pronto,
    output logic [LARGURA_PONTOS-1:0] pontos,
    output logic [3:0]                db_estado
);

    localparam int                        TIMER_W    = $clog2(TIMEOUT_CICLOS);
    localparam logic [TIMER_W-1:0]        TIMER_FIM  = TIMER_W'(TIMEOUT_CICLOS - 1);
    localparam logic [LARGURA_PONTOS-1:0] PONTOS_MAX = '1;

    estado_t                   r_estado;
    logic                      r_nova;
    logic [COORD_W-1:0]        r_alvo_col;
    logic [COORD_W-1:0]        r_alvo_lin;
    logic [COORD_W-1:0]        r_jog_col;
    logic [COORD_W-1:0]        r_jog_lin;
    logic                      r_acertou;
    logic                      r_errou;
    logic                      r_timeout;
    logic                      r_pronto;
    logic [LARGURA_PONTOS-1:0] r_pontos;
    logic [TIMER_W-1:0]        r_timer;

    logic                      w_valido;
    logic [COORD_W-1:0]        w_valor;
    logic                      w_espera;
    logic                      w_expirou;

    codificador_botoes u_codificador (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_botoes (botoes),
        .o_valido (w_valido),
        .o_valor  (w_valor)
    );

    assign w_espera  = (r_estado == ESP_COL) || (r_estado == ESP_LIN);
    // A press in the deadline cycle wins because the FSM tests w_valido first.
    assign w_expirou = (r_timer == TIMER_FIM);

    // Keypress deadline: runs only while waiting for a key, restarts on each accepted press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_espera && !w_valido) begin
            r_timer <= r_timer + TIMER_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Round FSM with registered outputs, target/answer capture and score.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_nova     <= 1'b0;
            r_alvo_col <= '0;
            r_alvo_lin <= '0;
            r_jog_col  <= '0;
            r_jog_lin  <= '0;
            r_acertou  <= 1'b0;
            r_errou    <= 1'b0;
            r_timeout  <= 1'b0;
            r_pronto   <= 1'b1;
            r_pontos   <= '0;
        end else begin
            r_nova <= 1'b0;
            case (r_estado)
                INICIAL, ACERTO, ERRO, TEMPO: begin
                    if (iniciar) begin
                        r_estado  <= PEDE;
                        r_nova    <= 1'b1;
                        r_jog_col <= '0;
                        r_jog_lin <= '0;
                        r_acertou <= 1'b0;
                        r_errou   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_pronto  <= 1'b0;
                    end
                end
                PEDE: begin
                    r_estado <= CAPTURA;
                end
                CAPTURA: begin
                    if (coord_valida(coluna) && coord_valida(linha)) begin
                        r_alvo_col <= coluna;
                        r_alvo_lin <= linha;
                        r_estado   <= ESP_COL;
                    end else begin
                        // Off-board target: ask the generator again.
                        r_estado <= PEDE;
                        r_nova   <= 1'b1;
                    end
                end
                ESP_COL: begin
                    if (w_valido) begin
                        r_jog_col <= w_valor;
                        r_estado  <= ESP_LIN;
                    end else if (w_expirou) begin
                        r_estado  <= TEMPO;
                        r_timeout <= 1'b1;
                        r_pronto  <= 1'b1;
                    end
                end
                ESP_LIN: begin
                    if (w_valido) begin
                        r_jog_lin <= w_valor;
                        r_estado  <= COMPARA;
                    end else if (w_expirou) begin
                        r_estado  <= TEMPO;
                        r_timeout <= 1'b1;
                        r_pronto  <= 1'b1;
                    end
                end
                COMPARA: begin
                    r_pronto <= 1'b1;
                    if ((r_jog_col == r_alvo_col) && (r_jog_lin == r_alvo_lin)) begin
                        r_estado  <= ACERTO;
                        r_acertou <= 1'b1;
                        if (r_pontos != PONTOS_MAX) begin
                            r_pontos <= r_pontos + LARGURA_PONTOS'(1);
                        end
                    end else begin
                        r_estado <= ERRO;
                        r_errou  <= 1'b1;
                    end
                end
                default: begin
                    r_estado  <= INICIAL;
                    r_acertou <= 1'b0;
                    r_errou   <= 1'b0;
                    r_timeout <= 1'b0;
                    r_pronto  <= 1'b1;
                end
            endcase
        end
    end

    assign novaJogada    = r_nova;
    assign alvo_coluna   = r_alvo_col;
    assign alvo_linha    = r_alvo_lin;
    assign jogada_coluna = r_jog_col;
    assign jogada_linha  = r_jog_lin;
    assign acertou       = r_acertou;
    assign errou         = r_errou;
    assign timeout       = r_timeout;
    assign pronto        = r_pronto;
    assign pontos        = r_pontos;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_verificador_jogadas.sv
// Bench for verificador_jogadas: directed rounds, a generator model that
// answers novaJogada from a queue, and a scoreboard monitor that checks
// each round result when a result flag rises.
module tb_verificador_jogadas;

    localparam int TO = 10;
    localparam int LP = 8;

    typedef struct packed {
        logic          acertou;
        logic          errou;
        logic          timeout;
        logic [LP-1:0] pontos;
        logic [3:0]    jc;
        logic [3:0]    jl;
        logic [3:0]    ac;
        logic [3:0]    al;
    } res_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [7:0]    botoes;
    logic [3:0]    coluna;
    logic [3:0]    linha;
    logic          novaJogada;
    logic [3:0]    alvo_coluna;
    logic [3:0]    alvo_linha;
    logic [3:0]    jogada_coluna;
    logic [3:0]    jogada_linha;
    logic          acertou;
    logic          errou;
    logic          timeout;
    logic          pronto;
    logic [LP-1:0] pontos;
    logic [3:0]    db_estado;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   nj_count = 0;
    int   exp_pontos = 0;
    res_t sb_q[$];
    logic [7:0] gen_q[$];
    logic [7:0] g_tmp;
    logic prev_flag = 1'b0;
    res_t mon_act;
    res_t mon_exp;

    verificador_jogadas #(
        .TIMEOUT_CICLOS (TO),
        .LARGURA_PONTOS (LP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .botoes        (botoes),
        .coluna        (coluna),
        .linha         (linha),
        .novaJogada    (novaJogada),
        .alvo_coluna   (alvo_coluna),
        .alvo_linha    (alvo_linha),
        .jogada_coluna (jogada_coluna),
        .jogada_linha  (jogada_linha),
        .acertou       (acertou),
        .errou         (errou),
        .timeout       (timeout),
        .pronto        (pronto),
        .pontos        (pontos),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Move-generator model: answers each request with the next queued target.
    always @(negedge clock) begin
        if (novaJogada === 1'b1) begin
            nj_count = nj_count + 1;
            if (gen_q.size() > 0) begin
                g_tmp  = gen_q.pop_front();
                coluna = g_tmp[7:4];
                linha  = g_tmp[3:0];
            end
        end
    end

    // Scoreboard monitor: a rising result flag presents one round result.
    always @(negedge clock) begin
        if ((acertou | errou | timeout) === 1'b1 && !prev_flag) begin
            mon_act = {acertou, errou, timeout, pontos, jogada_coluna, jogada_linha,
                       alvo_coluna, alvo_linha};
            n_vec = n_vec + 1;
            if (sb_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL resultado_inesperado: got %h, none expected", mon_act);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err = n_err + 1;
                    $display("FAIL resultado: got %h (a%b e%b t%b p%0d j%0d/%0d alvo%0d/%0d) expected %h (a%b e%b t%b p%0d j%0d/%0d alvo%0d/%0d)",
                             mon_act, mon_act.acertou, mon_act.errou, mon_act.timeout, mon_act.pontos,
                             mon_act.jc, mon_act.jl, mon_act.ac, mon_act.al,
                             mon_exp, mon_exp.acertou, mon_exp.errou, mon_exp.timeout, mon_exp.pontos,
                             mon_exp.jc, mon_exp.jl, mon_exp.ac, mon_exp.al);
                end
            end
        end
        prev_flag <= ((acertou | errou | timeout) === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic a, input logic e, input logic t, input int p,
                                input logic [3:0] jc, input logic [3:0] jl,
                                input logic [3:0] ac, input logic [3:0] al);
        res_t r;
        r.acertou = a;
        r.errou   = e;
        r.timeout = t;
        r.pontos  = LP'(p);
        r.jc      = jc;
        r.jl      = jl;
        r.ac      = ac;
        r.al      = al;
        return r;
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (db_estado === s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", db_estado, s, budget);
        end
    endtask

    // Returns the bench cycle count at the first negedge where timeout is high, -1 if never.
    task automatic wait_timeout(input int budget, output int tc);
        tc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (timeout === 1'b1) begin
                tc = cyc;
                break;
            end
        end
    endtask

    task automatic start_round();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Key held across one rising edge, then released for one; t = cycle count when driven.
    task automatic press(input logic [7:0] k, output int t);
        botoes = k;
        t = cyc;
        @(negedge clock);
        botoes = 8'h00;
        @(negedge clock);
    endtask

    initial begin
        int t, tc, e, nj0;
        reset   = 1'b1;
        iniciar = 1'b0;
        botoes  = 8'h00;
        coluna  = 4'd0;
        linha   = 4'd0;
        repeat (2) @(negedge clock);

        chk("rst_pronto", pronto, 1);
        chk("rst_novaJogada", novaJogada, 0);
        chk("rst_flags", {acertou, errou, timeout}, 0);
        chk("rst_pontos", pontos, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_coords", {alvo_coluna, alvo_linha, jogada_coluna, jogada_linha}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_estado", db_estado, 0);

        // 1: target 3/5, keys 0x04 then 0x10 -> hit
        gen_q.push_back(8'h35);
        exp_pontos = 1;
        sb_q.push_back(mk(1, 0, 0, exp_pontos, 4'd3, 4'd5, 4'd3, 4'd5));
        start_round();
        wait_state(4'd3, 20);
        press(8'h04, t);
        botoes = 8'h10;
        @(negedge clock);
        chk("t1_flag_em_compara", acertou, 0);
        chk("t1_estado_compara", db_estado, 5);
        botoes = 8'h00;
        @(negedge clock);
        chk("t1_flag_apos_compara", acertou, 1);

        // 2: target 3/5, keys 0x04 then 0x08 -> miss, score unchanged
        gen_q.push_back(8'h35);
        sb_q.push_back(mk(0, 1, 0, exp_pontos, 4'd3, 4'd4, 4'd3, 4'd5));
        start_round();
        wait_state(4'd3, 20);
        press(8'h04, t);
        press(8'h08, t);
        wait_state(4'd7, 10);

        // 3: generator gives off-board 0 then 9 before 2/7
        gen_q.push_back(8'h05);
        gen_q.push_back(8'h95);
        gen_q.push_back(8'h27);
        nj0 = nj_count;
        exp_pontos = 2;
        sb_q.push_back(mk(1, 0, 0, exp_pontos, 4'd2, 4'd7, 4'd2, 4'd7));
        start_round();
        wait_state(4'd3, 40);
        chk("t3_pedidos", nj_count - nj0, 3);
        press(8'h02, t);
        press(8'h40, t);
        wait_state(4'd6, 10);

        // 4: column key then silence -> timeout 10 cycles after the press is taken
        gen_q.push_back(8'h44);
        sb_q.push_back(mk(0, 0, 1, exp_pontos, 4'd4, 4'd0, 4'd4, 4'd4));
        start_round();
        wait_state(4'd3, 20);
        press(8'h08, t);
        wait_timeout(40, tc);
        chk("t4_latencia_timeout", tc - (t + 1), TO);

        // 5a: chord 0x06 then 0x04 with no release -> nothing captured, timer unaffected
        gen_q.push_back(8'h66);
        sb_q.push_back(mk(0, 0, 1, exp_pontos, 4'd0, 4'd0, 4'd6, 4'd6));
        start_round();
        wait_state(4'd3, 20);
        e = cyc;
        botoes = 8'h06;
        @(negedge clock);
        botoes = 8'h04;
        wait_timeout(40, tc);
        chk("t5_timer_sem_captura", tc - e, TO);
        botoes = 8'h00;

        // 5b: valid 0x04 kept held -> row never taken; iniciar mid-round ignored
        gen_q.push_back(8'h66);
        sb_q.push_back(mk(0, 0, 1, exp_pontos, 4'd3, 4'd0, 4'd6, 4'd6));
        start_round();
        wait_state(4'd3, 20);
        botoes = 8'h04;
        t = cyc;
        tc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (timeout === 1'b1) begin
                tc = cyc;
                break;
            end
            iniciar = (i == 3);
        end
        iniciar = 1'b0;
        botoes  = 8'h00;
        chk("t5_segurado_timeout", tc - (t + 1), TO);

        // 6: reset in ESP_LIN, then saturate the score
        gen_q.push_back(8'h11);
        start_round();
        wait_state(4'd3, 20);
        press(8'h01, t);
        chk("t6_em_esp_lin", db_estado, 4);
        reset = 1'b1;
        #1;
        chk("t6_rst_pronto", pronto, 1);
        chk("t6_rst_estado", db_estado, 0);
        chk("t6_rst_pontos", pontos, 0);
        chk("t6_rst_flags", {novaJogada, acertou, errou, timeout}, 0);
        chk("t6_rst_coords", {alvo_coluna, alvo_linha, jogada_coluna, jogada_linha}, 0);
        @(negedge clock);
        reset = 1'b0;
        nj0 = nj_count;
        repeat (4) @(negedge clock);
        chk("t6_sem_pedido", nj_count - nj0, 0);
        chk("t6_estado_inicial", db_estado, 0);
        exp_pontos = 0;
        for (int i = 0; i < 256; i++) begin
            exp_pontos = (exp_pontos < 255) ? exp_pontos + 1 : 255;
            gen_q.push_back(8'h88);
            sb_q.push_back(mk(1, 0, 0, exp_pontos, 4'd8, 4'd8, 4'd8, 4'd8));
            start_round();
            wait_state(4'd3, 20);
            press(8'h80, t);
            press(8'h80, t);
            wait_state(4'd6, 10);
        end
        chk("t6_pontos_saturado", pontos, 255);

        repeat (3) @(negedge clock);
        chk("scoreboard_vazio", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
